// File: rtl/edge_gen_if.sv
// edge_gen_if: command handshake between a level/hold producer and edge_gen.
interface edge_gen_if #(
    parameter int CntWidth = 8
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic                req_level_i;
    logic [CntWidth-1:0] req_hold_i;
    modport master (output req_valid_i, req_level_i, req_hold_i, input req_ready_o);
    modport slave  (input req_valid_i, req_level_i, req_hold_i, output req_ready_o);
endinterface

// File: rtl/edge_gen.sv
// edge_gen: drives serial_o with commanded levels, each held for max(req_hold, MinHold) cycles.
// EDGE_GEN_EDGE_CNT_EN adds edge_cnt_o, a wrapping count of emitted edges.
module edge_gen #(
    parameter int   CntWidth   = 8,
    parameter int   MinHold    = 2,
    parameter logic ResetLevel = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    edge_gen_if.slave        req,
    output logic             serial_o,
    output logic             re_o,
    output logic             fe_o,
`ifdef EDGE_GEN_EDGE_CNT_EN
    output logic [CntWidth-1:0] edge_cnt_o,
`endif
    output logic             busy_o
);
    if (MinHold < 1 || MinHold >= 2**CntWidth) begin : g_bad_min_hold
        $error("edge_gen: MinHold must satisfy 1 <= MinHold < 2**CntWidth");
    end

    localparam logic [CntWidth-1:0] MIN_H = CntWidth'(MinHold);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              r_state, w_next;
    logic [CntWidth-1:0] r_cnt;
    logic                r_serial, r_re, r_fe;
    logic                w_ready, w_load, w_change;
    logic [CntWidth-1:0] w_hold;

    assign w_hold   = (req.req_hold_i < MIN_H) ? MIN_H : req.req_hold_i;
    assign w_change = req.req_level_i != r_serial;

    always_comb begin
        w_next  = r_state;
        w_ready = (r_state == IDLE) || (r_cnt == '0);
        w_load  = w_ready && req.req_valid_i;
        if (w_load)
            w_next = HOLD;
        else if (r_state == HOLD && r_cnt == '0)
            w_next = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_serial <= ResetLevel;
            r_re     <= 1'b0;
            r_fe     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_re    <= w_load && w_change && req.req_level_i;
            r_fe    <= w_load && w_change && !req.req_level_i;
            if (w_load) begin
                r_serial <= req.req_level_i;
                r_cnt    <= w_hold - CntWidth'(1);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CntWidth'(1);
            end
        end
    end

`ifdef EDGE_GEN_EDGE_CNT_EN
    logic [CntWidth-1:0] r_edge_cnt;
    // Counts alongside the strobe register so edge_cnt_o steps in the strobe cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i)
            r_edge_cnt <= '0;
        else if (w_load && w_change)
            r_edge_cnt <= r_edge_cnt + CntWidth'(1);
    end
    assign edge_cnt_o = r_edge_cnt;
`endif

    assign req.req_ready_o = w_ready;
    assign serial_o        = r_serial;
    assign re_o            = r_re;
    assign fe_o            = r_fe;
    assign busy_o          = r_state == HOLD;
endmodule

// File: tb/tb_edge_gen.sv
// tb_edge_gen: directed and random commands checked against a timeline model of edge_gen.
module tb_edge_gen;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic clr_i = 1'b0;
    logic serial_o, re_o, fe_o, busy_o;
`ifdef EDGE_GEN_EDGE_CNT_EN
    logic [7:0] edge_cnt_o;
`endif

    edge_gen_if #(.CntWidth(8)) bus ();

    edge_gen #(.CntWidth(8), .MinHold(2), .ResetLevel(1'b0)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (clr_i),
        .req      (bus.slave),
        .serial_o (serial_o),
        .re_o     (re_o),
        .fe_o     (fe_o),
`ifdef EDGE_GEN_EDGE_CNT_EN
        .edge_cnt_o (edge_cnt_o),
`endif
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   known = 0;
    // Timeline model: cycle of last accept, cycle when the next command may be accepted.
    int   m_last_acc = 0;
    int   m_ready_at = 0;
    logic m_level = 1'b0;
    logic m_re = 1'b0;
    logic m_fe = 1'b0;
    logic [7:0] m_ecnt = 8'd0;
    int   m_edges = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic l, input logic [7:0] h, input logic c, input logic r);
        int hold;
        @(negedge clk_i);
        bus.req_valid_i = v;
        bus.req_level_i = l;
        bus.req_hold_i  = h;
        clr_i = c;
        rst_i = r;
        if (known) begin
            chk("serial", serial_o, m_level);
            chk("re", re_o, m_re);
            chk("fe", fe_o, m_fe);
            chk("ready", bus.req_ready_o, cyc >= m_ready_at);
            chk("busy", busy_o, cyc > m_last_acc && cyc <= m_ready_at);
`ifdef EDGE_GEN_EDGE_CNT_EN
            checks++;
            assert (edge_cnt_o === m_ecnt) else begin
                errors++;
                $error("FAIL edge_cnt cycle=%0d observed=%0d expected=%0d", cyc, edge_cnt_o, m_ecnt);
            end
`endif
        end
        if (r || c) begin
            m_level = 1'b0;
            m_re = 1'b0;
            m_fe = 1'b0;
            m_ecnt = 8'd0;
            m_ready_at = cyc + 1;
            m_last_acc = cyc + 1;
        end else if (v && cyc >= m_ready_at) begin
            hold = (int'(h) < 2) ? 2 : int'(h);
            m_re = l && !m_level;
            m_fe = !l && m_level;
            if (m_re || m_fe) begin
                m_ecnt = m_ecnt + 8'd1;
                m_edges++;
            end
            m_level = l;
            m_last_acc = cyc;
            m_ready_at = cyc + hold;
        end else begin
            m_re = 1'b0;
            m_fe = 1'b0;
        end
        if (r) known = 1;
        @(posedge clk_i);
        cyc++;
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_level_i = 1'b0;
        bus.req_hold_i  = 8'd0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 1, 8'd5, 0, 0);
        repeat (7) step(0, 0, 0, 0, 0);
        step(1, 1, 8'd3, 0, 0);
        repeat (2) step(1, 0, 8'd3, 0, 0);
        step(1, 0, 8'd3, 0, 0);
        repeat (2) step(1, 1, 8'd3, 0, 0);
        step(1, 1, 8'd3, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 8'd0, 0, 0);
        step(1, 1, 8'd1, 0, 0);
        step(1, 1, 8'd1, 0, 0);
        step(1, 0, 8'd1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 8'd4, 0, 0);
        repeat (6) step(0, 0, 0, 0, 0);
        step(1, 1, 8'd6, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(1, 1, 8'd4, 0, 0);
        step(1, 0, 8'd2, 1, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 7), 1'($urandom), 8'($urandom_range(0, 6)),
                 ($urandom_range(0, 39) == 0), 1'b0);
`ifdef EDGE_GEN_EDGE_CNT_EN
        step(0, 0, 0, 1, 0);
        m_edges = 0;
        for (int i = 0; i < 2000 && m_edges < 257; i++)
            step(1, !m_level, 8'd0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        assert (edge_cnt_o === 8'd1) else begin
            errors++;
            $error("FAIL edge_cnt_wrap observed=%0d expected=1", edge_cnt_o);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
`endif
        step(0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
